// File: rtl/uart_tx_port.sv
// uart_tx_port: memory-mapped 8N1 serial transmitter with a byte FIFO,
// a sticky overflow flag and a level drain interrupt.
// Optional even parity bit is compiled in with `UART_TX_PARITY_EN.
// Ports: clk; reset (async, active high);
//   data_in/a0/wr/rd: CPU bus (a0=0 data, a0=1 control/status);
//   data_out: read mux; interrupt: level irq to PIC;
//   tx: serial line (idle high); busy: frame in progress.
module uart_tx_port #(
  parameter int unsigned CLKS_PER_BIT = 434,
  parameter int unsigned FIFO_DEPTH   = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [15:0] data_in,
  input  logic        a0,
  input  logic        wr,
  input  logic        rd,
  output logic [15:0] data_out,
  output logic        interrupt,
  output logic        tx,
  output logic        busy
);

  localparam int unsigned AW = $clog2(FIFO_DEPTH);
  localparam int unsigned BW = $clog2(CLKS_PER_BIT);
  localparam logic [BW-1:0] BAUD_LAST = BW'(CLKS_PER_BIT - 1);
  localparam logic [4:0] DEPTH_C = 5'(FIFO_DEPTH);

`ifdef UART_TX_PARITY_EN
  typedef enum logic [2:0] {
    S_IDLE, S_START, S_DATA, S_PARITY, S_STOP
  } state_t;
`else
  typedef enum logic [2:0] {
    S_IDLE, S_START, S_DATA, S_STOP
  } state_t;
`endif

  logic [7:0]    mem_q [FIFO_DEPTH];
  logic [AW-1:0] wp_q, wp_d, rp_q, rp_d;
  logic [4:0]    cnt_q, cnt_d;

  state_t        state_q;
  logic [BW-1:0] baud_q;
  logic [2:0]    idx_q;
  logic [7:0]    shift_q;
  logic          tx_q, busy_q;

  logic          ie_q, ovf_q, irq_q;
  logic [7:0]    last_q;
  logic          pe_bit;

  logic push, ctl_wr, empty, full;
  logic pop, push_ok, ovf_set, bit_end;
  logic unused_bits;

  assign push    = wr & ~a0;
  assign ctl_wr  = wr & a0;
  assign empty   = (cnt_q == 5'd0);
  assign full    = (cnt_q == DEPTH_C);
  assign pop     = (state_q == S_IDLE) & ~empty;
  // A pop in the same cycle frees the slot a full-FIFO push needs.
  assign push_ok = push & (~full | pop);
  assign ovf_set = push & full & ~pop;
  assign bit_end = (baud_q == BAUD_LAST);

  assign unused_bits = ^{data_in[15:8], data_in[1]};

  always_comb begin
    wp_d  = wp_q;
    rp_d  = rp_q;
    cnt_d = cnt_q;
    if (push_ok) wp_d = wp_q + AW'(1);
    if (pop)     rp_d = rp_q + AW'(1);
    unique case ({push_ok, pop})
      2'b10:   cnt_d = cnt_q + 5'd1;
      2'b01:   cnt_d = cnt_q - 5'd1;
      default: cnt_d = cnt_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (push_ok) mem_q[wp_q] <= data_in[7:0];
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wp_q  <= '0;
      rp_q  <= '0;
      cnt_q <= '0;
    end else begin
      wp_q  <= wp_d;
      rp_q  <= rp_d;
      cnt_q <= cnt_d;
    end
  end

`ifdef UART_TX_PARITY_EN
  logic pe_q, par_q;
  assign pe_bit = pe_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset)       pe_q <= 1'b0;
    else if (ctl_wr) pe_q <= data_in[1];
  end
`else
  assign pe_bit = 1'b0;
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ie_q   <= 1'b0;
      ovf_q  <= 1'b0;
      irq_q  <= 1'b0;
      last_q <= 8'h00;
    end else begin
      if (ctl_wr) ie_q <= data_in[0];
      if (push)   last_q <= data_in[7:0];
      if (ovf_set)        ovf_q <= 1'b1;
      else if (rd & a0)   ovf_q <= 1'b0;
      irq_q <= ie_q & empty & ~busy_q;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
      baud_q  <= '0;
      idx_q   <= '0;
      shift_q <= '0;
      tx_q    <= 1'b1;
      busy_q  <= 1'b0;
`ifdef UART_TX_PARITY_EN
      par_q   <= 1'b0;
`endif
    end else begin
      unique case (state_q)
        S_IDLE: begin
          if (pop) begin
            state_q <= S_START;
            baud_q  <= '0;
            shift_q <= mem_q[rp_q];
            tx_q    <= 1'b0;
            busy_q  <= 1'b1;
`ifdef UART_TX_PARITY_EN
            // Parity choice is frozen per frame.
            par_q   <= pe_q;
`endif
          end
        end
        S_START: begin
          if (bit_end) begin
            state_q <= S_DATA;
            baud_q  <= '0;
            idx_q   <= '0;
            tx_q    <= shift_q[0];
          end else begin
            baud_q  <= baud_q + BW'(1);
          end
        end
        S_DATA: begin
          if (bit_end) begin
            baud_q <= '0;
            if (idx_q == 3'd7) begin
`ifdef UART_TX_PARITY_EN
              if (par_q) begin
                state_q <= S_PARITY;
                tx_q    <= ^shift_q;
              end else begin
                state_q <= S_STOP;
                tx_q    <= 1'b1;
              end
`else
              state_q <= S_STOP;
              tx_q    <= 1'b1;
`endif
            end else begin
              idx_q <= idx_q + 3'd1;
              tx_q  <= shift_q[idx_q + 3'd1];
            end
          end else begin
            baud_q <= baud_q + BW'(1);
          end
        end
`ifdef UART_TX_PARITY_EN
        S_PARITY: begin
          if (bit_end) begin
            state_q <= S_STOP;
            baud_q  <= '0;
            tx_q    <= 1'b1;
          end else begin
            baud_q  <= baud_q + BW'(1);
          end
        end
`endif
        S_STOP: begin
          if (bit_end) begin
            state_q <= S_IDLE;
            baud_q  <= '0;
            tx_q    <= 1'b1;
            busy_q  <= 1'b0;
          end else begin
            baud_q  <= baud_q + BW'(1);
          end
        end
        default: begin
          state_q <= S_IDLE;
          baud_q  <= '0;
          tx_q    <= 1'b1;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign data_out  = a0 ? {5'b0, pe_bit, cnt_q, ovf_q,
                           ie_q, busy_q, empty, ~full}
                        : {8'h00, last_q};
  assign interrupt = irq_q;
  assign tx        = tx_q;
  assign busy      = busy_q;

endmodule

// File: tb/tb_uart_tx_port.sv
// tb_uart_tx_port: randomized and directed stimulus for uart_tx_port,
// compared every cycle against a frame-level reference model.
module tb_uart_tx_port;

  localparam int C = 4;
  localparam int D = 4;

  logic        clk = 1'b0;
  logic        reset;
  logic [15:0] data_in;
  logic        a0, wr, rd;
  logic [15:0] data_out;
  logic        interrupt, tx, busy;

  uart_tx_port #(.CLKS_PER_BIT(C), .FIFO_DEPTH(D)) dut (
    .clk(clk), .reset(reset), .data_in(data_in), .a0(a0),
    .wr(wr), .rd(rd), .data_out(data_out),
    .interrupt(interrupt), .tx(tx), .busy(busy)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_err = 0;

  // Reference model: queue of pending bytes plus one frame in flight,
  // described by its byte and elapsed cycle t.
  logic [7:0] q_m[$];
  bit         busy_m, fpar_m;
  int         t_m;
  logic [7:0] fb_m, last_m;
  bit         ie_m, pe_m, ovf_m, irq_m;
  logic [15:0] last_dout;

  task automatic check(input string tag, input logic [15:0] got,
                       input logic [15:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    q_m.delete();
    busy_m = 0; fpar_m = 0; t_m = 0; fb_m = 0; last_m = 0;
    ie_m = 0; pe_m = 0; ovf_m = 0; irq_m = 0;
  endtask

  function automatic logic exp_tx();
    int n;
    if (!busy_m) return 1'b1;
    n = t_m / C;
    if (n == 0) return 1'b0;
    if (n <= 8) return fb_m[n-1];
    if (fpar_m && n == 9) return ^fb_m;
    return 1'b1;
  endfunction

  function automatic logic [15:0] exp_dout(input bit a);
    int sz;
    logic [4:0] s5;
    sz = q_m.size();
    s5 = 5'(sz);
    if (!a) return {8'h00, last_m};
    return {5'b0, pe_m, s5, ovf_m, ie_m, busy_m, sz == 0, sz < D};
  endfunction

  task automatic model_edge(input bit w, input bit a, input bit r,
                            input logic [15:0] d);
    int  sz, len;
    bit  pop, irq_n;
    sz    = q_m.size();
    pop   = !busy_m && sz != 0;
    irq_n = ie_m && sz == 0 && !busy_m;
    if (busy_m) begin
      len = (fpar_m ? 11 : 10) * C;
      t_m++;
      if (t_m == len) busy_m = 0;
    end else if (pop) begin
      fb_m = q_m.pop_front();
      busy_m = 1; t_m = 0; fpar_m = pe_m;
    end
    if (r && a) ovf_m = 0;
    if (w && !a) begin
      last_m = d[7:0];
      if (sz < D || pop) q_m.push_back(d[7:0]);
      else ovf_m = 1;
    end
    if (w && a) begin
      ie_m = d[0];
`ifdef UART_TX_PARITY_EN
      pe_m = d[1];
`endif
    end
    irq_m = irq_n;
  endtask

  task automatic step(input bit w, input bit a, input bit r,
                      input logic [15:0] d);
    wr = w; a0 = a; rd = r; data_in = d;
    #1;
    last_dout = data_out;
    check("dout", data_out, exp_dout(a));
    @(posedge clk);
    model_edge(w, a, r, d);
    #1;
    check("tx", {15'b0, tx}, {15'b0, exp_tx()});
    check("busy", {15'b0, busy}, {15'b0, busy_m});
    check("irq", {15'b0, interrupt}, {15'b0, irq_m});
  endtask

  task automatic idle();
    step(0, 1'($urandom_range(0, 1)), 0, 16'h0);
  endtask

  task automatic drain();
    for (int i = 0; i < 3000 && (busy_m || q_m.size() != 0); i++) idle();
    idle();
    check("drain_busy", {15'b0, busy}, 16'h0);
  endtask

  task automatic busy_len(output int n);
    n = 0;
    for (int i = 0; i < 200; i++) begin
      idle();
      if (busy) n++;
      else if (n > 0) break;
    end
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n, first, lastb;
    bit found;
    reset = 1'b1; wr = 0; rd = 0; a0 = 0; data_in = 0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check("rst_tx", {15'b0, tx}, 16'h1);
    check("rst_busy", {15'b0, busy}, 16'h0);
    check("rst_irq", {15'b0, interrupt}, 16'h0);
    reset = 1'b0;
    step(0, 1, 0, 0);
    check("rst_stat", last_dout, 16'h0003);

    // Single byte 5A: 40 busy cycles, waveform by model.
    step(1, 0, 0, 16'h005A);
    busy_len(n);
    check("busy40", 16'(n), 16'd40);
    drain();

    // Fill and overflow.
    for (int i = 1; i <= 6; i++) step(1, 0, 0, 16'(i));
    step(0, 1, 1, 0);
    check("ovf_set", {15'b0, last_dout[4]}, 16'h1);
    check("ovf_cnt", {11'b0, last_dout[9:5]}, 16'd4);
    step(0, 1, 0, 0);
    check("ovf_clr", {15'b0, last_dout[4]}, 16'h0);
    drain();

    // Interrupt behaviour.
    step(1, 1, 0, 16'h0001);
    step(1, 0, 0, 16'h00FF);
    n = 0;
    for (int i = 0; i < 200; i++) begin
      idle();
      if (busy) begin
        n++;
        check("irq_busy", {15'b0, interrupt}, 16'h0);
      end else if (n > 0) break;
    end
    check("irq_edge", {15'b0, interrupt}, 16'h0);
    idle();
    check("irq_rise", {15'b0, interrupt}, 16'h1);
    step(1, 0, 0, 16'h0012);
    idle();
    check("irq_drop_data", {15'b0, interrupt}, 16'h0);
    drain();
    idle();
    check("irq_back", {15'b0, interrupt}, 16'h1);
    step(1, 1, 0, 16'h0000);
    idle();
    check("irq_drop_ie", {15'b0, interrupt}, 16'h0);

    // Back-to-back frames.
    step(1, 0, 0, 16'h0000);
    step(1, 0, 0, 16'h00FF);
    first = -1; lastb = -1;
    for (int i = 0; i < 300; i++) begin
      idle();
      if (busy) begin
        if (first < 0) first = i;
        lastb = i;
      end else if (first >= 0 && q_m.size() == 0 && !busy_m) break;
    end
    n = lastb - first + 1;
    check("b2b_span", 16'(n >= 80 && n <= 81), 16'h1);
    drain();

`ifdef UART_TX_PARITY_EN
    step(1, 1, 0, 16'h0002);
    step(1, 0, 0, 16'h0007);
    busy_len(n);
    check("par_busy44", 16'(n), 16'd44);
    drain();
    step(1, 1, 0, 16'h0000);
    step(1, 0, 0, 16'h0007);
    busy_len(n);
    check("nopar_busy40", 16'(n), 16'd40);
    drain();
`endif

    // Randomized traffic: heavy phase, then light phase.
    for (int ph = 0; ph < 2; ph++) begin
      for (int i = 0; i < 3000; i++) begin
        int r;
        r = $urandom_range(0, 99);
        if (r < (ph == 0 ? 25 : 3))
          step(1, 0, 0, 16'($urandom));
        else if (r < (ph == 0 ? 30 : 5))
          step(1, 1, 0, 16'($urandom_range(0, 3)));
        else if (r < (ph == 0 ? 40 : 10))
          step(0, 1, 1, 0);
        else
          idle();
      end
      drain();
    end

    // Reset in the middle of a frame (DATA bit 3).
    step(1, 1, 0, 16'h0001);
    step(1, 0, 0, 16'h00A5);
    found = 0;
    for (int i = 0; i < 100; i++) begin
      idle();
      if (busy_m && t_m / C == 4) begin
        found = 1;
        break;
      end
    end
    check("mid_found", {15'b0, found}, 16'h1);
    wr = 0; rd = 0; a0 = 0;
    reset = 1'b1;
    #1;
    check("mid_tx", {15'b0, tx}, 16'h1);
    check("mid_busy", {15'b0, busy}, 16'h0);
    check("mid_irq", {15'b0, interrupt}, 16'h0);
    model_reset();
    @(posedge clk);
    #1;
    reset = 1'b0;
    step(0, 1, 0, 0);
    check("mid_stat", last_dout, 16'h0003);
    repeat (5) idle();

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule

// File: doc/uart_tx_port.md
Name: uart_tx_port

Overview:
- Memory-mapped, interrupt-capable serial transmitter. It is the output-direction counterpart of the switchbank input devices.
- CPU writes bytes through a two-register interface (a0 selects data or control/status). Bytes queue in a small FIFO and are shifted out 8N1, LSB first, on `tx`.
- Raises a level interrupt on a PIC irq line when the FIFO has drained. The interrupt is held until serviced.

Parameters:
- CLKS_PER_BIT, 434, clk cycles per serial bit (50 MHz / 115200); legal range 2..65535.
- FIFO_DEPTH, 4, byte entries in the transmit FIFO; must be a power of 2, 2..16.

Ports:
- clk  in  1  system clock; all logic on posedge.
- reset  in  1  asynchronous, active-high reset.
- data_in  in  16  CPU write data (cpu data_out); only [7:0] is used for data writes.
- a0  in  1  register select: 0 = data, 1 = control/status.
- wr  in  1  write strobe, one cycle per write (memwt qualified by address decode).
- rd  in  1  read strobe, one cycle per read (address decode, ackx style).
- data_out  out  16  read data to the CPU input mux; combinational from a0.
- interrupt  out  1  level irq to the PIC.
- tx  out  1  serial line; idle high.
- busy  out  1  high while a frame is being shifted.

Behaviour:
- Reset (async, any state, mid-frame included):
  - tx=1, busy=0, interrupt=0.
  - FIFO emptied (count=0, pointers 0), IE=0, overflow=0.
  - FSM goes to IDLE and the baud counter goes to 0.
- Writes:
  - wr & a0=0: push data_in[7:0] into the FIFO. The entry is visible in count on the next cycle.
  - wr & a0=1: IE <= data_in[0]; other bits are ignored.
- Reads:
  - a0=1 returns status:
    - bit0 ready (count < FIFO_DEPTH)
    - bit1 empty (count == 0)
    - bit2 busy
    - bit3 IE
    - bit4 overflow
    - bits[9:5] count
    - all other bits 0.
  - rd & a0=1 clears overflow at the end of that cycle. The read itself still returns the pre-clear value.
  - a0=0 returns {8'h00, last byte written}.
- FIFO boundaries:
  - Push while full and no pop in that cycle: byte dropped, overflow <= 1 (sticky), FIFO unchanged.
  - Push while full with a pop in the same cycle: push accepted, count unchanged.
  - Push and pop in the same cycle when not full: count unchanged, order preserved.
  - Pointers wrap modulo FIFO_DEPTH.
- FSM states: IDLE, START, DATA, STOP.
  - IDLE: tx=1, busy=0. If count != 0, pop the head into the shift register and go to START; tx drops low on the next cycle.
  - START: tx=0 for CLKS_PER_BIT cycles, then DATA with bit index 0.
  - DATA: tx=shift[idx] for CLKS_PER_BIT cycles each, idx 0..7. After idx 7 go to STOP.
  - STOP: tx=1 for CLKS_PER_BIT cycles, then IDLE.
  - busy=1 in START, DATA and STOP.
  - The baud counter counts 0..CLKS_PER_BIT-1 and reloads 0 on every state/bit change.
- Back-to-back frames: if the FIFO is non-empty when STOP ends, the next START begins within 1 cycle of IDLE entry. Gap is at most 1 clk of extra idle.
- Interrupt:
  - interrupt = IE & empty & ~busy, registered (1-cycle latency).
  - Stays asserted until the CPU pushes a byte or clears IE. There is no separate ack.
- Writes arriving mid-frame never disturb the byte being shifted.

Optional Feature:
- Macro `UART_TX_PARITY_EN`.
- Defined:
  - Adds state PARITY between DATA and STOP. tx = XOR of the 8 data bits (even parity) for CLKS_PER_BIT cycles; frame is 11 bits.
  - Control write bit1 = parity enable (PE, reset 0). When PE=0 the PARITY state is skipped.
  - Status bit10 = PE.
- Undefined: no PARITY state, control bit1 ignored, status bit10 reads 0, frame always 10 bits.

Test Plan:
- Reset mid-frame (CLKS_PER_BIT=4): write 8'hA5, assert reset during DATA idx 3 -> tx=1, busy=0 immediately; status reads 16'h0003 after reset release.
- Single byte: write 8'h5A at a0=0 -> tx: 1-cycle latency, then 4 clk low, then bits 0,1,0,1,1,0,1,0 (4 clk each), then 4 clk high; busy high for exactly 40 cycles.
- Fill and overflow (FIFO_DEPTH=4): 6 writes 8'h01..8'h06 in consecutive cycles.
  - Required: first byte popped into shifter; 01..05 transmitted in order; 06 dropped.
  - Required: status bit4=1 and count=4 immediately after the 6th write.
  - Required: status read clears bit4; the next status read shows bit4=0.
- Interrupt: write control 16'h0001, send 8'hFF -> interrupt=0 while busy; 1 clk after STOP ends interrupt=1. A data write drops it next cycle; a control write 16'h0000 drops it next cycle.
- Back-to-back: write 8'h00 then 8'hFF -> second START begins at most 1 clk after first STOP; total 80-81 cycles.
- With `UART_TX_PARITY_EN`: control 16'h0002, write 8'h07 -> parity bit 1 appears after bit 7; busy for 44 cycles. With PE=0, busy for 40 cycles.
